// File: rtl/adas_ctrl_gen2.sv
// adas_ctrl_gen2: longitudinal ADAS / autonomous controller with lidar/camera fusion,
// moving average, detector voting and sensor-disagreement fault. Option: ADAS_SPD_HYST_EN.
module adas_ctrl_gen2 #(
  parameter int DW        = 8,
  parameter int AVG_LOG2  = 2,
  parameter int N_SENS    = 2,
  parameter int VOTE_MIN  = 2,
  parameter int DIFF_TH   = 20,
  parameter int PED_SPD   = 20,
  parameter int FAULT_CNT = 3,
  parameter int DEF_DIST  = 50,
  parameter int DEF_SPD   = 100,
  parameter int HYST      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timer_tick_i,
  input  logic              mod_i,
  input  logic [N_SENS-1:0] red_i,
  input  logic [N_SENS-1:0] ped_i,
  input  logic [DW-1:0]     dist_lidar_i,
  input  logic [DW-1:0]     dist_cam_i,
  input  logic [DW-1:0]     dist_set_i,
  input  logic [DW-1:0]     spd_meas_i,
  input  logic [DW-1:0]     spd_set_i,
  output logic              gas_o,
  output logic              brake_o,
  output logic              red_warn_o,
  output logic              ped_warn_o,
  output logic              dist_warn_o,
  output logic              fault_o,
  output logic [1:0]        state_o
);

  localparam int unsigned NB = (1 << AVG_LOG2) - 1;
  localparam int SW = DW + AVG_LOG2;
  localparam int CW = $clog2(FAULT_CNT + 1);
  localparam int VW = $clog2(N_SENS + 1);
  localparam logic [DW-1:0] DIFF_TH_W = DW'(DIFF_TH);
  localparam logic [DW-1:0] PED_SPD_W = DW'(PED_SPD);
  localparam logic [CW-1:0] FAULT_W   = CW'(FAULT_CNT);
  localparam logic [VW-1:0] VOTE_W    = VW'(VOTE_MIN);

  typedef enum logic [1:0] {
    ST_ASSIST = 2'b00,
    ST_TRANS  = 2'b01,
    ST_AUTO   = 2'b11,
    ST_FAULT  = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dist_set_q, dist_set_d, spd_set_q, spd_set_d;
  logic [DW-1:0] hist_q [NB];
  logic [DW-1:0] hist_d [NB];
  logic [CW-1:0] cnt_q, cnt_d;
  logic gas_q, gas_d, brake_q, brake_d;
  logic red_warn_q, red_warn_d, ped_warn_q, ped_warn_d;
  logic dist_warn_q, dist_warn_d, fault_q, fault_d;

  logic [DW-1:0] diff, fused, avg;
  logic [DW:0]   pair_sum;
  logic [SW-1:0] sum;
  logic [VW-1:0] red_cnt, ped_cnt;
  logic          agree, fault, red_det, ped_det;

`ifdef ADAS_SPD_HYST_EN
  localparam logic [DW-1:0] HYST_W = DW'(HYST);
  logic [DW-1:0] spd_lo, spd_hi;
  // Set when the previous AUTO decision came from a step above the speed step;
  // a hysteresis hold must then not keep that brake.
  logic          hp_q, hp_d;
`endif

  always_comb begin
    diff     = (dist_lidar_i >= dist_cam_i) ? dist_lidar_i - dist_cam_i
                                            : dist_cam_i - dist_lidar_i;
    agree    = diff < DIFF_TH_W;
    pair_sum = {1'b0, dist_lidar_i} + {1'b0, dist_cam_i};
    fused    = agree ? pair_sum[DW:1] : dist_lidar_i;

    sum = SW'(fused);
    for (int unsigned i = 0; i < NB; i++) sum = sum + SW'(hist_q[i]);
    avg = sum[SW-1:AVG_LOG2];

    hist_d[0] = fused;
    for (int unsigned i = 1; i < NB; i++) hist_d[i] = hist_q[i-1];

    red_cnt = '0;
    ped_cnt = '0;
    for (int unsigned i = 0; i < N_SENS; i++) begin
      red_cnt = red_cnt + VW'(red_i[i]);
      ped_cnt = ped_cnt + VW'(ped_i[i]);
    end
    red_det = red_cnt >= VOTE_W;
    ped_det = ped_cnt >= VOTE_W;

    if (agree)                cnt_d = '0;
    else if (cnt_q == FAULT_W) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 1'b1;
    // Decisions on a tick see the count including that tick.
    fault   = cnt_d == FAULT_W;
    fault_d = fault;

`ifdef ADAS_SPD_HYST_EN
    spd_lo = (spd_set_q > HYST_W) ? spd_set_q - HYST_W : '0;
    spd_hi = (spd_set_q > ('1 - HYST_W)) ? '1 : spd_set_q + HYST_W;
    hp_d   = 1'b0;
`endif

    state_d     = state_q;
    dist_set_d  = dist_set_q;
    spd_set_d   = spd_set_q;
    gas_d       = gas_q;
    brake_d     = brake_q;
    red_warn_d  = red_warn_q;
    ped_warn_d  = ped_warn_q;
    dist_warn_d = dist_warn_q;

    unique case (state_q)
      ST_ASSIST: begin
        if (mod_i) begin
          red_warn_d  = 1'b0;
          ped_warn_d  = 1'b0;
          dist_warn_d = 1'b0;
          state_d     = ST_TRANS;
        end else begin
          red_warn_d  = red_det;
          ped_warn_d  = ped_det;
          dist_warn_d = (avg < dist_set_q) || fault;
        end
      end
      ST_TRANS: begin
        if (!mod_i) begin
          state_d = ST_ASSIST;
        end else begin
          dist_set_d = dist_set_i;
          spd_set_d  = spd_set_i;
          state_d    = ST_AUTO;
        end
      end
      ST_AUTO: begin
        gas_d   = 1'b0;
        brake_d = 1'b0;
        if (!mod_i) begin
          state_d = ST_ASSIST;
        end else if (fault) begin
          brake_d = 1'b1;
          state_d = ST_FAULT;
        end else if (red_det || ped_det || (avg < dist_set_q)) begin
          brake_d = red_det || !ped_det || (spd_meas_i > PED_SPD_W);
`ifdef ADAS_SPD_HYST_EN
          hp_d    = 1'b1;
`endif
        end else begin
`ifdef ADAS_SPD_HYST_EN
          if (spd_meas_i < spd_lo) begin
            gas_d = 1'b1;
          end else if (spd_meas_i > spd_hi) begin
            brake_d = 1'b1;
          end else begin
            gas_d   = gas_q;
            brake_d = brake_q & ~hp_q;
          end
`else
          gas_d   = spd_meas_i < spd_set_q;
          brake_d = spd_meas_i > spd_set_q;
`endif
        end
      end
      ST_FAULT: begin
        if (!mod_i && !fault) begin
          gas_d       = 1'b0;
          brake_d     = 1'b0;
          red_warn_d  = 1'b0;
          ped_warn_d  = 1'b0;
          dist_warn_d = 1'b0;
          state_d     = ST_ASSIST;
        end else begin
          gas_d       = 1'b0;
          brake_d     = 1'b1;
          dist_warn_d = 1'b1;
        end
      end
      default: state_d = ST_ASSIST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSIST;
      dist_set_q  <= DW'(DEF_DIST);
      spd_set_q   <= DW'(DEF_SPD);
      for (int unsigned i = 0; i < NB; i++) hist_q[i] <= '0;
      cnt_q       <= '0;
      gas_q       <= 1'b0;
      brake_q     <= 1'b0;
      red_warn_q  <= 1'b0;
      ped_warn_q  <= 1'b0;
      dist_warn_q <= 1'b0;
      fault_q     <= 1'b0;
`ifdef ADAS_SPD_HYST_EN
      hp_q        <= 1'b0;
`endif
    end else if (timer_tick_i) begin
      state_q     <= state_d;
      dist_set_q  <= dist_set_d;
      spd_set_q   <= spd_set_d;
      for (int unsigned i = 0; i < NB; i++) hist_q[i] <= hist_d[i];
      cnt_q       <= cnt_d;
      gas_q       <= gas_d;
      brake_q     <= brake_d;
      red_warn_q  <= red_warn_d;
      ped_warn_q  <= ped_warn_d;
      dist_warn_q <= dist_warn_d;
      fault_q     <= fault_d;
`ifdef ADAS_SPD_HYST_EN
      hp_q        <= hp_d;
`endif
    end
  end

  assign gas_o       = gas_q;
  assign brake_o     = brake_q;
  assign red_warn_o  = red_warn_q;
  assign ped_warn_o  = ped_warn_q;
  assign dist_warn_o = dist_warn_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

endmodule

// File: doc/adas_ctrl_gen2.md
Name: adas_ctrl_gen2

Overview:
- Parametrised second-generation driver-assistance / autonomous longitudinal controller.
- Fuses lidar and camera distance, keeps a 2^AVG_LOG2-deep moving average, votes N_SENS detector channels for red light and crosswalk, and drives gas/brake (autonomous) or warnings (assistance).
- Adds a sensor-disagreement FAULT state.
- Sits between the sensor front-end and the actuator/HMI interface; all decisions are taken on the 1 ms timer tick.

Parameters:
- DW, 8, width of distance/speed inputs (m, km/h).
- AVG_LOG2, 2, log2 of moving-average depth D=2^AVG_LOG2 (1..4).
- N_SENS, 2, detector channels per event (red light, crosswalk).
- VOTE_MIN, 2, channels that must assert for an event to be detected (1..N_SENS).
- DIFF_TH, 20, lidar/camera disagreement threshold.
- PED_SPD, 20, max speed allowed over a crosswalk.
- FAULT_CNT, 3, consecutive disagreeing ticks that raise a fault.
- DEF_DIST, 50, reset follow distance.
- DEF_SPD, 100, reset cruise speed.
- HYST, 2, speed hysteresis half-band (used only with ADAS_SPD_HYST_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- timer_tick_i  in  1  one-cycle pulse every 1 ms
- mod_i  in  1  0 = assistance, 1 = autonomous request
- red_i  in  N_SENS  red-light detector votes
- ped_i  in  N_SENS  crosswalk detector votes
- dist_lidar_i  in  DW  lidar distance
- dist_cam_i  in  DW  camera distance
- dist_set_i  in  DW  requested follow distance
- spd_meas_i  in  DW  measured speed
- spd_set_i  in  DW  requested cruise speed
- gas_o  out  1  throttle request
- brake_o  out  1  brake request
- red_warn_o  out  1  red-light warning
- ped_warn_o  out  1  crosswalk warning
- dist_warn_o  out  1  follow-distance warning
- fault_o  out  1  sensor-disagreement fault
- state_o  out  2  current state code

Behaviour:
- Reset: all outputs 0; state ASSIST; dist_set_r=DEF_DIST; spd_set_r=DEF_SPD; average buffer all 0; disagreement counter 0.
- Registers change only on cycles with timer_tick_i=1. Otherwise everything holds, the buffer included.
- Fusion (comb): diff=|lidar-cam|. If diff<DIFF_TH, fused=(lidar+cam)>>1 using a DW+1-bit sum; else fused=lidar.
- Average (comb): avg=(fused + newest D-1 buffer entries)>>AVG_LOG2, sum width DW+AVG_LOG2, no overflow.
- On each tick, fused is shifted into the buffer and the oldest entry is dropped.
- Votes: red_det = popcount(red_i)>=VOTE_MIN; ped_det likewise.
- Fault counter: on a tick, increments (saturating at FAULT_CNT) when diff>=DIFF_TH; clears to 0 when diff<DIFF_TH. fault = (count==FAULT_CNT). fault_o is registered with 1-tick latency.
- States: ASSIST=00, TRANS=01, AUTO=11, FAULT=10; state_o = state.
- ASSIST, per tick:
  - red_warn=red_det; ped_warn=ped_det; dist_warn = avg<dist_set_r OR fault.
  - If mod_i=1: clear all warnings, go to TRANS.
- TRANS, per tick:
  - If mod_i=0: go to ASSIST, set-points unchanged.
  - Else latch dist_set_i/spd_set_i into dist_set_r/spd_set_r, go to AUTO.
- AUTO, per tick:
  - If mod_i=0: gas=brake=0, go to ASSIST.
  - Else if fault: brake=1, gas=0, go to FAULT.
  - Else decide by priority, highest first:
    - red_det: brake.
    - ped_det: brake if spd_meas>PED_SPD, else coast (0/0).
    - avg<dist_set_r: brake.
    - spd_meas<spd_set_r: gas.
    - spd_meas==spd_set_r: coast.
    - else: brake.
- FAULT, per tick:
  - brake=1, gas=0, dist_warn=1.
  - Exits only when mod_i=0 and fault=0: clear all outputs, go to ASSIST.
  - mod_i=0 with fault still set: stay in FAULT.
- Invariant: gas_o and brake_o are never both 1.
- Simultaneous tick + mode change + fault: the priorities above apply in order.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro ADAS_SPD_HYST_EN.
- Defined: in the AUTO speed step, gas when spd_meas < spd_set_r-HYST; brake when spd_meas > spd_set_r+HYST; otherwise hold previous gas/brake.
  - Bounds saturate at 0 and 2^DW-1.
  - A hold that follows a higher-priority brake resolves to coast.
- Undefined: exact comparison as in Behaviour; HYST is ignored.

Test Plan:
- Reset, no tick for 10 cycles -> all outputs 0, state_o=00, buffer unchanged.
- ASSIST, lidar=cam=40, 4 ticks with default depth -> avg=40<50, dist_warn_o=1; red_i=2'b01 with VOTE_MIN=2 -> red_warn_o=0.
- mod_i=1, dist_set_i=30, spd_set_i=60 -> TRANS after tick 1, AUTO after tick 2; spd_meas=50, avg=40 -> gas_o=1; spd_meas=70 -> brake_o=1.
- AUTO, ped_i=2'b11, spd_meas=15 -> gas_o=0, brake_o=0; add red_i=2'b11 -> brake_o=1.
- AUTO, lidar=100, cam=50 for 3 ticks -> fault_o=1, state FAULT, brake_o=1; mod_i=0 with diff still 50 -> stays FAULT; diff<20 and mod_i=0 -> ASSIST, outputs 0.
- ADAS_SPD_HYST_EN defined, set=60, HYST=2, spd_meas=59 after gas -> gas_o held 1; spd_meas=63 -> brake_o=1.
